rf_gen: RTL and testbench
=========================

Name: rf_gen

Overview:
Parametrised register file for the pico datapath, the next generation of the 8-bit/32-entry register file.
- Register 0 is hardwired to zero.
- One register is a memory-mapped external input capture register.
- One register is a memory-mapped external output register with a valid/ready handshake.
- Adds optional write-to-read bypass and a per-register pending scoreboard so the pipeline can detect RAW hazards.

Parameters:
DATA_W, 8, data width in bits
NUM_REGS, 32, number of registers; must be a power of two, at least 4
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
EXT_IN_IDX, 30, index of the external input register (read-only to the core)
EXT_OUT_IDX, 31, index of the external output register
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports; 0 = registered reads only

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
wr_en_i  in  1  write request
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  signed write data
wr_stall_o  out  1  write refused this cycle (external output busy)
rs_addr_i  in  ADDR_W  read port A address
rt_addr_i  in  ADDR_W  read port B address
rs_data_o  out  DATA_W  signed read data A
rt_data_o  out  DATA_W  signed read data B
rsv_en_i  in  1  reserve a destination (instruction issue)
rsv_addr_i  in  ADDR_W  address to reserve
rs_pending_o  out  1  rs_addr_i has an outstanding producer
rt_pending_o  out  1  rt_addr_i has an outstanding producer
ext_valid_i  in  1  external input strobe
ext_data_i  in  DATA_W  external input data
ext_out_data_o  out  DATA_W  contents of EXT_OUT_IDX
ext_out_valid_o  out  1  external output holds unconsumed data
ext_out_ready_i  in  1  consumer accepts ext_out_data_o

Behaviour:
Reset (rst_ni low, takes effect immediately):
- All registers 0.
- ext_out_valid_o 0.
- All pending bits 0.

Reads are combinational from the register array.
- Address 0 always reads 0, including under bypass.
- With BYPASS=1, a read address equal to an accepted write address returns wr_data_i in the same cycle.
- No bypass for address 0 or EXT_IN_IDX.
- Both read ports are independent and may use the same address.

Write acceptance:
- wr_accept = wr_en_i and not wr_stall_o; the write lands on the next rising edge.
- Writes to address 0 or EXT_IN_IDX are accepted but discarded.
- wr_stall_o = wr_en_i and wr_addr_i==EXT_OUT_IDX and ext_out_valid_o and not ext_out_ready_i. It is combinational.

External input:
- On any edge with ext_valid_i=1, regs[EXT_IN_IDX] <= ext_data_i.
- Otherwise the register holds its value. There is no free-running capture.

External output handshake:
- An accepted write to EXT_OUT_IDX sets ext_out_valid_o on the next edge.
- Transfer occurs on any edge with valid and ready both 1; valid clears unless an accepted write to EXT_OUT_IDX occurs in the same cycle, in which case valid stays 1 with the new data.
- ext_out_data_o = regs[EXT_OUT_IDX], registered.
- Core reads of EXT_OUT_IDX return the same value.

Scoreboard (one bit per register):
- rsv_en_i sets pending[rsv_addr_i].
- An accepted write clears pending[wr_addr_i].
- If a reserve and a write hit the same address in the same edge, the reserve wins and the bit ends up 1.
- A stalled write does not clear its pending bit.
- Reserves to address 0 or EXT_IN_IDX are ignored.
- rs_pending_o / rt_pending_o are combinational lookups. With BYPASS=1 they read 0 when the matching write is accepted in the same cycle.
- Address 0 never reads pending.

Arithmetic: none; data is passed through bit-exact, with no sign extension inside the block.

Elaboration checks:
- EXT_IN_IDX != EXT_OUT_IDX.
- Neither index is 0.
- Both indices < NUM_REGS.

Decomposition:
Package rf_pkg holds:
- default DATA_W and NUM_REGS localparams;
- the ZERO_IDX constant;
- default EXT_IN_IDX and EXT_OUT_IDX;
- a function is_writable(addr) shared by the data path and the scoreboard.

One sub-module, rf_scoreboard, holds the pending bit-vector with its reserve/clear logic and the two lookup ports. The array, bypass and handshake logic stay in rf_gen.

Test Plan:
1. Reset with rst_ni asserted mid-cycle, then write 0x5A to r3 → all reads 0 immediately on reset; r3 reads 0x5A after the next edge. A write of 0x77 to r0 → r0 still reads 0.
2. Bypass: BYPASS=1, write 0x81 to r7 with rs_addr=rt_addr=7 in the same cycle → both outputs 0x81 that cycle. Repeat with BYPASS=0 → old value that cycle, 0x81 the next.
3. External input: ext_data_i=0x3C with ext_valid_i=0 → r30 unchanged. Pulse ext_valid_i → r30=0x3C next cycle. Core write 0x11 to r30 → r30 stays 0x3C.
4. External output: write 0x42 to r31 with ready=0 → valid=1 and data=0x42 next cycle. A second write 0x43 → wr_stall_o=1 and r31 stays 0x42. Set ready=1 and write 0x43 → valid stays 1 and data becomes 0x43. Next edge with ready=1 and no write → valid=0.
5. Scoreboard: reserve r5 → rs_pending=1 for rs_addr=5. A stalled write to r5 does not apply (use EXT_OUT busy on r31, check r5 unaffected). An accepted write to r5 clears the bit. A reserve and write to r5 in the same edge → pending=1.
6. Reset mid-handshake: valid=1 with pending bits set, pull rst_ni low → ext_out_valid_o=0 and all pending bits 0 without waiting for a clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the rf_gen register file and its scoreboard.
package rf_pkg;

    localparam int unsigned DEFAULT_DATA_W      = 8;
    localparam int unsigned DEFAULT_NUM_REGS    = 32;
    localparam int unsigned ZERO_IDX            = 0;
    localparam int unsigned DEFAULT_EXT_IN_IDX  = 30;
    localparam int unsigned DEFAULT_EXT_OUT_IDX = 31;

    // True when a core write or reservation to addr has any architectural effect.
    function automatic logic is_writable(input int unsigned addr, input int unsigned ext_in_idx);
        return (addr != ZERO_IDX) && (addr != ext_in_idx);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW hazard detection: set on reserve, cleared on write.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int unsigned ADDR_W     = $clog2(NUM_REGS),
    parameter int unsigned EXT_IN_IDX = DEFAULT_EXT_IN_IDX,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic              rs_pending_o,
    output logic              rt_pending_o
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                rs_hit, rt_hit;

    // Reserve is applied after the clear so a same-edge collision leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (rsv_en_i && is_writable(32'(rsv_addr_i), EXT_IN_IDX)) begin
            pending_d[rsv_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rs_hit       = BYPASS && clr_en_i && (clr_addr_i == rs_addr_i);
        rt_hit       = BYPASS && clr_en_i && (clr_addr_i == rt_addr_i);
        rs_pending_o = pending_q[rs_addr_i] && !rs_hit && (rs_addr_i != '0);
        rt_pending_o = pending_q[rt_addr_i] && !rt_hit && (rt_addr_i != '0);
    end

endmodule

// File: rtl/rf_gen.sv
// Parametrised register file with zero register, external I/O registers, optional
// write-to-read bypass and a pending scoreboard.
module rf_gen
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int unsigned ADDR_W      = $clog2(NUM_REGS),
    parameter int unsigned EXT_IN_IDX  = DEFAULT_EXT_IN_IDX,
    parameter int unsigned EXT_OUT_IDX = DEFAULT_EXT_OUT_IDX,
    parameter bit          BYPASS      = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_stall_o,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              rs_pending_o,
    output logic              rt_pending_o,
    input  logic              ext_valid_i,
    input  logic [DATA_W-1:0] ext_data_i,
    output logic [DATA_W-1:0] ext_out_data_o,
    output logic              ext_out_valid_o,
    input  logic              ext_out_ready_i
);

    if (EXT_IN_IDX == EXT_OUT_IDX) begin : g_err_same_idx
        $error("rf_gen: EXT_IN_IDX and EXT_OUT_IDX must differ");
    end
    if (EXT_IN_IDX == ZERO_IDX || EXT_OUT_IDX == ZERO_IDX) begin : g_err_zero_idx
        $error("rf_gen: external register index must not be 0");
    end
    if (EXT_IN_IDX >= NUM_REGS || EXT_OUT_IDX >= NUM_REGS) begin : g_err_range_idx
        $error("rf_gen: external register index out of range");
    end
    if (NUM_REGS < 4 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_err_num_regs
        $error("rf_gen: NUM_REGS must be a power of two, at least 4");
    end

    localparam logic [ADDR_W-1:0] ExtInAddr  = ADDR_W'(EXT_IN_IDX);
    localparam logic [ADDR_W-1:0] ExtOutAddr = ADDR_W'(EXT_OUT_IDX);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              ext_out_valid_q, ext_out_valid_d;
    logic              wr_accept;
    logic              wr_effective;
    logic              byp_ok;

    assign wr_stall_o   = wr_en_i && (wr_addr_i == ExtOutAddr) && ext_out_valid_q
                          && !ext_out_ready_i;
    assign wr_accept    = wr_en_i && !wr_stall_o;
    assign wr_effective = wr_accept && is_writable(32'(wr_addr_i), EXT_IN_IDX);
    assign byp_ok       = BYPASS && wr_effective;

    always_comb begin
        regs_d = regs_q;
        if (wr_effective) begin
            regs_d[wr_addr_i] = wr_data_i;
        end
        if (ext_valid_i) begin
            regs_d[ExtInAddr] = ext_data_i;
        end
    end

    // A new write in the transfer cycle keeps valid high with the fresh data.
    always_comb begin
        ext_out_valid_d = ext_out_valid_q;
        if (wr_accept && (wr_addr_i == ExtOutAddr)) begin
            ext_out_valid_d = 1'b1;
        end else if (ext_out_valid_q && ext_out_ready_i) begin
            ext_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            ext_out_valid_q <= 1'b0;
        end else begin
            regs_q          <= regs_d;
            ext_out_valid_q <= ext_out_valid_d;
        end
    end

    always_comb begin
        rs_data_o = regs_q[rs_addr_i];
        if (byp_ok && (rs_addr_i == wr_addr_i)) begin
            rs_data_o = wr_data_i;
        end
        if (rs_addr_i == '0) begin
            rs_data_o = '0;
        end
    end

    always_comb begin
        rt_data_o = regs_q[rt_addr_i];
        if (byp_ok && (rt_addr_i == wr_addr_i)) begin
            rt_data_o = wr_data_i;
        end
        if (rt_addr_i == '0) begin
            rt_data_o = '0;
        end
    end

    assign ext_out_data_o  = regs_q[ExtOutAddr];
    assign ext_out_valid_o = ext_out_valid_q;

    rf_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_W     (ADDR_W),
        .EXT_IN_IDX (EXT_IN_IDX),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rsv_en_i     (rsv_en_i),
        .rsv_addr_i   (rsv_addr_i),
        .clr_en_i     (wr_accept),
        .clr_addr_i   (wr_addr_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rs_pending_o (rs_pending_o),
        .rt_pending_o (rt_pending_o)
    );

endmodule

// File: tb/tb_rf_gen.sv
// Randomised self-checking bench for rf_gen; runs a bypass and a non-bypass instance side by side.
module tb_rf_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [4:0] rs_addr = '0;
    logic [4:0] rt_addr = '0;
    logic       rsv_en = 1'b0;
    logic [4:0] rsv_addr = '0;
    logic       ext_valid = 1'b0;
    logic [7:0] ext_data = '0;
    logic       ready = 1'b0;

    logic       stall_b, stall_n, pend_rs_b, pend_rt_b, pend_rs_n, pend_rt_n, xo_valid_b, xo_valid_n;
    logic [7:0] rs_b, rt_b, rs_n, rt_n, xo_data_b, xo_data_n;

    always #5 clk = ~clk;

    rf_gen #(.BYPASS(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_stall_o(stall_b), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_b), .rt_data_o(rt_b), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .rs_pending_o(pend_rs_b), .rt_pending_o(pend_rt_b), .ext_valid_i(ext_valid),
        .ext_data_i(ext_data), .ext_out_data_o(xo_data_b), .ext_out_valid_o(xo_valid_b),
        .ext_out_ready_i(ready)
    );

    rf_gen #(.BYPASS(1'b0)) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_stall_o(stall_n), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_n), .rt_data_o(rt_n), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .rs_pending_o(pend_rs_n), .rt_pending_o(pend_rt_n), .ext_valid_i(ext_valid),
        .ext_data_i(ext_data), .ext_out_data_o(xo_data_n), .ext_out_valid_o(xo_valid_n),
        .ext_out_ready_i(ready)
    );

    // Reference model: architectural state only.
    logic [7:0] m_regs [32];
    bit         m_pend [32];
    bit         m_valid;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
    endtask

    function automatic bit m_stall();
        return wr_en && (wr_addr == 5'd31) && m_valid && !ready;
    endfunction

    function automatic bit m_accept();
        return wr_en && !m_stall();
    endfunction

    function automatic bit lands(input logic [4:0] a);
        return m_accept() && (wr_addr == a) && (a != 5'd0) && (a != 5'd30);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 8'h00;
        if (byp && lands(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && m_accept() && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic check_all();
        check("stall_b", 32'(stall_b), 32'(m_stall()));
        check("stall_n", 32'(stall_n), 32'(m_stall()));
        check("rs_b", 32'(rs_b), 32'(exp_rd(rs_addr, 1'b1)));
        check("rt_b", 32'(rt_b), 32'(exp_rd(rt_addr, 1'b1)));
        check("rs_n", 32'(rs_n), 32'(exp_rd(rs_addr, 1'b0)));
        check("rt_n", 32'(rt_n), 32'(exp_rd(rt_addr, 1'b0)));
        check("pend_rs_b", 32'(pend_rs_b), 32'(exp_pend(rs_addr, 1'b1)));
        check("pend_rt_b", 32'(pend_rt_b), 32'(exp_pend(rt_addr, 1'b1)));
        check("pend_rs_n", 32'(pend_rs_n), 32'(exp_pend(rs_addr, 1'b0)));
        check("pend_rt_n", 32'(pend_rt_n), 32'(exp_pend(rt_addr, 1'b0)));
        check("xo_data_b", 32'(xo_data_b), 32'(m_regs[31]));
        check("xo_data_n", 32'(xo_data_n), 32'(m_regs[31]));
        check("xo_valid_b", 32'(xo_valid_b), 32'(m_valid));
        check("xo_valid_n", 32'(xo_valid_n), 32'(m_valid));
    endtask

    task automatic apply(input bit we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt, input bit rv,
                         input logic [4:0] ra, input bit ev, input logic [7:0] ed,
                         input bit rdy);
        wr_en = we; wr_addr = wa; wr_data = wd; rs_addr = rs; rt_addr = rt;
        rsv_en = rv; rsv_addr = ra; ext_valid = ev; ext_data = ed; ready = rdy;
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    // Advance one edge, updating the model from the inputs held across it.
    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = m_accept();
        if (lands(wr_addr)) m_regs[wr_addr] = wr_data;
        if (ext_valid) m_regs[30] = ext_data;
        if (acc && wr_addr == 5'd31) m_valid = 1'b1;
        else if (m_valid && ready) m_valid = 1'b0;
        if (acc) m_pend[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != 5'd0 && rsv_addr != 5'd30) m_pend[rsv_addr] = 1'b1;
        #1;
    endtask

    task automatic step(input bit we, input logic [4:0] wa, input logic [7:0] wd,
                        input logic [4:0] rs, input logic [4:0] rt, input bit rv,
                        input logic [4:0] ra, input bit ev, input logic [7:0] ed,
                        input bit rdy);
        apply(we, wa, wd, rs, rt, rv, ra, ev, ed, rdy);
        settle();
        tick();
    endtask

    function automatic logic [4:0] rnd_addr();
        logic [4:0] hot [6];
        hot = '{5'd0, 5'd3, 5'd5, 5'd7, 5'd30, 5'd31};
        if ($urandom_range(0, 1) == 0) return hot[$urandom_range(0, 5)];
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_rs_b", 32'(rs_b), 32'h0);
        check("rst_valid", 32'(xo_valid_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write and zero register.
        step(1, 5'd3, 8'h5A, 5'd3, 5'd3, 0, 5'd0, 0, 8'h00, 0);
        apply(1, 5'd0, 8'h77, 5'd3, 5'd0, 0, 5'd0, 0, 8'h00, 0);
        settle();
        check("t1_r3", 32'(rs_n), 32'h5A);
        check("t1_r0_byp", 32'(rt_b), 32'h00);
        tick();
        step(0, 5'd0, 8'h00, 5'd0, 5'd0, 0, 5'd0, 0, 8'h00, 0);

        // Bypass versus registered read.
        apply(1, 5'd7, 8'h81, 5'd7, 5'd7, 0, 5'd0, 0, 8'h00, 0);
        settle();
        check("t2_byp_rs", 32'(rs_b), 32'h81);
        check("t2_nobyp_rt", 32'(rt_n), 32'h00);
        tick();
        apply(0, 5'd0, 8'h00, 5'd7, 5'd7, 0, 5'd0, 0, 8'h00, 0);
        settle();
        check("t2_nobyp_next", 32'(rs_n), 32'h81);
        tick();

        // External input capture.
        step(0, 5'd0, 8'h00, 5'd30, 5'd30, 0, 5'd0, 0, 8'h3C, 0);
        step(0, 5'd0, 8'h00, 5'd30, 5'd30, 0, 5'd0, 1, 8'h3C, 0);
        step(1, 5'd30, 8'h11, 5'd30, 5'd30, 0, 5'd0, 0, 8'h3C, 0);
        apply(0, 5'd0, 8'h00, 5'd30, 5'd30, 0, 5'd0, 0, 8'h00, 0);
        settle();
        check("t3_r30", 32'(rs_b), 32'h3C);
        tick();

        // External output handshake.
        step(1, 5'd31, 8'h42, 5'd31, 5'd0, 0, 5'd0, 0, 8'h00, 0);
        apply(1, 5'd31, 8'h43, 5'd31, 5'd31, 0, 5'd0, 0, 8'h00, 0);
        settle();
        check("t4_stall", 32'(stall_b), 32'h1);
        check("t4_stall_nobyp_rd", 32'(rs_b), 32'h42);
        tick();
        check("t4_hold", 32'(xo_data_n), 32'h42);
        step(1, 5'd31, 8'h43, 5'd31, 5'd0, 0, 5'd0, 0, 8'h00, 1);
        check("t4_new_valid", 32'(xo_valid_b), 32'h1);
        check("t4_new_data", 32'(xo_data_b), 32'h43);
        step(0, 5'd0, 8'h00, 5'd31, 5'd0, 0, 5'd0, 0, 8'h00, 1);
        check("t4_drained", 32'(xo_valid_n), 32'h0);

        // Scoreboard: reserve, stalled write, clearing write, reserve-wins collision.
        step(1, 5'd31, 8'h50, 5'd5, 5'd31, 1, 5'd5, 0, 8'h00, 0);
        step(1, 5'd31, 8'h51, 5'd5, 5'd31, 1, 5'd31, 0, 8'h00, 0);
        apply(1, 5'd31, 8'h52, 5'd5, 5'd31, 0, 5'd0, 0, 8'h00, 0);
        settle();
        check("t5_r5_pend", 32'(pend_rs_b), 32'h1);
        check("t5_r31_pend_stalled", 32'(pend_rt_b), 32'h1);
        tick();
        step(1, 5'd5, 8'h55, 5'd5, 5'd5, 0, 5'd0, 0, 8'h00, 0);
        check("t5_cleared", 32'(pend_rs_n), 32'h0);
        step(1, 5'd5, 8'h56, 5'd5, 5'd5, 1, 5'd5, 0, 8'h00, 0);
        check("t5_rsv_wins", 32'(pend_rs_n), 32'h1);

        // Asynchronous reset mid-handshake.
        step(1, 5'd31, 8'h99, 5'd9, 5'd5, 1, 5'd9, 0, 8'h00, 0);
        apply(0, 5'd0, 8'h00, 5'd9, 5'd5, 0, 5'd0, 0, 8'h00, 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_valid", 32'(xo_valid_b), 32'h0);
        check("t6_pend_rs", 32'(pend_rs_b), 32'h0);
        check("t6_pend_rt", 32'(pend_rt_n), 32'h0);
        check("t6_xo_data", 32'(xo_data_b), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
        @(posedge clk);
        #1;

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0, rnd_addr(), 8'($urandom), rnd_addr(), rnd_addr(),
                 $urandom_range(0, 2) == 0, rnd_addr(), $urandom_range(0, 3) == 0,
                 8'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
